instr_register_queue: RTL and testbench
=======================================

# instr_register_queue

Parametrised successor to the fixed 32-entry instruction register. It stores `instruction_t` words in a `DEPTH`-entry array and operates in one of two runtime modes. ADDR mode is random access with per-entry valid bits. FIFO mode uses a valid/ready write handshake and consuming reads. It sits between the instruction generator/testbench driver and the execution stage, and adds occupancy status, registered reads and sticky error flags.

## Interface
- `DEPTH`, 32: number of entries; power of two, 2..256.
- `AW`, `$clog2(DEPTH)`: pointer width; derived, never overridden.
- `clk`  input  1  clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `mode`  input  1  operating mode, `iw_mode_t`: `IW_ADDR`=0, `IW_FIFO`=1.
- `wr_valid`  input  1  write request.
- `wr_ready`  output  1  write can be accepted.
- `opcode`  input  `opcode_t`  opcode to store.
- `operand_a`, `operand_b`  input  `operand_t`  operands to store.
- `write_pointer`  input  AW  write index; used only in ADDR mode.
- `rd_req`  input  1  read request.
- `read_pointer`  input  AW  read index; used only in ADDR mode.
- `rd_valid`  output  1  `instruction_word` updated this cycle.
- `rd_hit`  output  1  the read entry held valid data.
- `instruction_word`  output  `instruction_t`  registered read data.
- `count`  output  AW+1  number of valid entries.
- `full`, `empty`  output  1  `count==DEPTH` / `count==0`.
- `overflow_err`, `underflow_err`  output  1  sticky error flags.
- `err_clr`  input  1  clears both error flags.

## Operation
- **Reset:**
  - every entry = `'{opc:ZERO, default:0}`, all valid bits 0.
  - `wptr` = `rptr` = 0, `count`=0, `empty`=1, `full`=0, `wr_ready`=1.
  - `rd_valid`=0, `rd_hit`=0, `instruction_word`=all zeros, both error flags 0.
- **Mode register:** `mode` is registered every cycle. When `mode` differs from the registered value:
  - that cycle is a flush: all valid bits cleared, pointers and `count` zeroed.
  - writes and reads in that cycle are ignored. Storage contents and error flags are untouched.
- **ADDR write:** `wr_ready`=1 always.
  - On `wr_valid`, `entry[write_pointer]` = {opcode, operand_a, operand_b} and its valid bit is set.
  - `count` increments only if that entry was previously invalid.
- **ADDR read:** `rd_req` is non-destructive.
  - Next cycle: `instruction_word` = `entry[read_pointer]`, `rd_valid`=1, `rd_hit` = the entry's valid bit.
  - A read of an invalid entry returns the stored data with `rd_hit`=0 and is not an error.
- **FIFO write:** `wr_ready` = `!full`.
  - When `wr_valid && wr_ready`: store at `wptr`, set its valid bit, `wptr` = (`wptr`+1) mod `DEPTH`.
  - When `wr_valid && full`: the data is dropped and `overflow_err` is set.
- **FIFO read:**
  - `rd_req && !empty`: next cycle `instruction_word` = `entry[rptr]`, `rd_valid`=1, `rd_hit`=1. The entry's valid bit is cleared and `rptr` = (`rptr`+1) mod `DEPTH`.
  - `rd_req && empty`: `rd_valid`=0, `underflow_err` set, no state change.
- **Simultaneous write and read (FIFO):**
  - Full: the read proceeds, the write is rejected (full is the registered value) and `overflow_err` is set.
  - Empty: the write is accepted and the read underflows (no fall-through).
  - Otherwise: both proceed and `count` is unchanged.
- **Simultaneous write and read to the same index (ADDR):** the read returns the old data.
- **Wrap:** pointers wrap silently; `full` and `empty` are derived from `count`, never from pointer equality.
- **Errors:** flags are sticky until `err_clr`. If `err_clr` and a new error occur in the same cycle, set wins.
- **Output hold:** `instruction_word` holds its last value whenever `rd_valid`=0.

## Timing
- Write commit: the rising edge where `wr_valid` (&& `wr_ready`) is sampled. `count`, `full` and `empty` reflect it from the next cycle.
- Read latency: 1 cycle from `rd_req` to `rd_valid`/`instruction_word`. `rd_valid` is a single-cycle pulse per accepted read, so back-to-back reads give one pulse per cycle.
- `wr_ready` is combinational from registered `full` and `mode` only; there is no path from `wr_valid`.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). The first accepted write is on the first edge after deassertion.

## Structure
- **`instr_register_pkg`:** add `iw_mode_t`. Reuse `opcode_t`, `operand_t`, `instruction_t` and the `ZERO` opcode. Pointers are local `logic [AW-1:0]`; the fixed `address_t` is not used.
- **Sub-module `iw_queue_ctrl`:** pointers, `count`, `full`/`empty`, flush and error flags. The top level holds the storage array, valid bits and the read register.

## Test plan
- **Reset:** assert `reset` mid-stream after 5 FIFO writes -> `count`=0, `empty`=1, `instruction_word`=0, `rd_valid`=0 immediately.
- **ADDR random access:** write opcode `ADD`, a=5, b=3 to index 7; read index 7 -> one cycle later `rd_valid`=1, `rd_hit`=1, word {ADD,5,3}. Read index 8 -> `rd_hit`=0. `count`=1; rewriting index 7 keeps `count`=1.
- **FIFO fill:** 32 writes with operand_a = 0..31 -> `full`=1, `wr_ready`=0. The 33rd write sets `overflow_err`. 32 reads return operand_a 0..31 in order, then `empty`=1.
- **FIFO underflow and wrap:** read when empty -> `underflow_err`=1, `rd_valid`=0. With `err_clr` the flag clears. Write/read 40 words one at a time -> pointer wraps and data stays in order.
- **Simultaneous FIFO events:**
  - Read and write at `count`=32 -> `count`=31 and `overflow_err` set.
  - Read and write at `count`=0 -> `count`=1 and `underflow_err` set.
  - Read and write at `count`=10 -> `count` stays 10.
- **Mode switch flush:** 4 entries valid in FIFO mode; toggle `mode` to ADDR with `wr_valid`=1 -> that write is ignored, `count`=0, and all `rd_hit`=0 thereafter. Repeat with `DEPTH`=4.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared instruction word types and the register's runtime mode.
// Opcode encoding matches the original fixed instruction register.
package instr_register_pkg;
   typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;

   typedef logic signed [31:0] operand_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
   } instruction_t;

   typedef enum logic {IW_ADDR = 1'b0, IW_FIFO = 1'b1} iw_mode_t;
endpackage

// File: rtl/instr_register_queue_if.sv
// Write/read/status bundle of the instruction register queue.
// The slave side is the register; the master side is the driver/execution stage.
interface instr_register_queue_if import instr_register_pkg::*; #(
   parameter int unsigned DEPTH = 32
);
   localparam int unsigned AW = $clog2(DEPTH);

   iw_mode_t        mode;
   logic            wr_valid;
   logic            wr_ready;
   opcode_t         opcode;
   operand_t        operand_a;
   operand_t        operand_b;
   logic [AW-1:0]   write_pointer;
   logic            rd_req;
   logic [AW-1:0]   read_pointer;
   logic            rd_valid;
   logic            rd_hit;
   instruction_t    instruction_word;
   logic [AW:0]     count;
   logic            full;
   logic            empty;
   logic            overflow_err;
   logic            underflow_err;
   logic            err_clr;

   modport slave (
      input  mode, wr_valid, opcode, operand_a, operand_b, write_pointer,
             rd_req, read_pointer, err_clr,
      output wr_ready, rd_valid, rd_hit, instruction_word, count, full, empty,
             overflow_err, underflow_err
   );

   modport master (
      output mode, wr_valid, opcode, operand_a, operand_b, write_pointer,
             rd_req, read_pointer, err_clr,
      input  wr_ready, rd_valid, rd_hit, instruction_word, count, full, empty,
             overflow_err, underflow_err
   );
endinterface

// File: rtl/iw_queue_ctrl.sv
// Pointers, occupancy, mode-change flush and sticky error flags; decides which writes/reads commit.
// Zero-latency decisions from registered state; FIFO writes are refused while full.
module iw_queue_ctrl import instr_register_pkg::*; #(
   parameter int unsigned DEPTH = 32,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  iw_mode_t      mode_i,
   input  logic          wr_valid_i,
   input  logic          rd_req_i,
   input  logic          err_clr_i,
   input  logic          addr_new_i,
   output logic          flush_o,
   output logic          wr_en_o,
   output logic          rd_en_o,
   output logic          wr_ready_o,
   output logic [AW-1:0] wptr_o,
   output logic [AW-1:0] rptr_o,
   output logic [AW:0]   count_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          ovf_o,
   output logic          unf_o
);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

   iw_mode_t      mode_q;
   logic          armed_q;
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d, unf_q, unf_d;
   logic          fifo, full, empty, ovf_set, unf_set;

   always_comb begin
      fifo       = (mode_i == IW_FIFO);
      full       = (count_q == FULL_CNT);
      empty      = (count_q == '0);
      // state is already clear straight after reset, so only later mode changes flush
      flush_o    = armed_q && (mode_i != mode_q);
      wr_ready_o = !fifo || !full;
      wr_en_o    = !flush_o && wr_valid_i && wr_ready_o;
      rd_en_o    = !flush_o && rd_req_i && (!fifo || !empty);
      ovf_set    = !flush_o && fifo && wr_valid_i && full;
      unf_set    = !flush_o && fifo && rd_req_i && empty;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      if (flush_o) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else if (fifo) begin
         if (wr_en_o) wptr_d = wptr_q + PTR_ONE;
         if (rd_en_o) rptr_d = rptr_q + PTR_ONE;
         if (wr_en_o && !rd_en_o)      count_d = count_q + CNT_ONE;
         else if (!wr_en_o && rd_en_o) count_d = count_q - CNT_ONE;
      end else if (wr_en_o && addr_new_i) begin
         count_d = count_q + CNT_ONE;
      end
      ovf_d = ovf_set || (ovf_q && !err_clr_i);
      unf_d = unf_set || (unf_q && !err_clr_i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= IW_ADDR;
         armed_q <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         mode_q  <= mode_i;
         armed_q <= 1'b1;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign wptr_o  = wptr_q;
   assign rptr_o  = rptr_q;
   assign count_o = count_q;
   assign full_o  = full;
   assign empty_o = empty;
   assign ovf_o   = ovf_q;
   assign unf_o   = unf_q;
endmodule

// File: rtl/instr_register_queue.sv
// DEPTH-entry instruction store: random access (ADDR) or consuming queue (FIFO), registered reads.
// Read data one cycle after rd_req; wr_ready drops only in FIFO mode when full.
module instr_register_queue import instr_register_pkg::*; #(
   parameter int unsigned DEPTH = 32
) (
   input logic                    clk,
   input logic                    reset,
   instr_register_queue_if.slave  bus
);
   localparam int unsigned  AW         = $clog2(DEPTH);
   localparam instruction_t RESET_WORD = '{opc: ZERO, default: '0};

   instruction_t [DEPTH-1:0] mem_q;
   logic [DEPTH-1:0]         valid_q;
   instruction_t             word_q;
   logic                     rd_valid_q, rd_hit_q;
   logic                     flush, wr_en, rd_en, fifo_mode;
   logic [AW-1:0]            wptr, rptr, widx, ridx;
   instruction_t             wr_word;

   iw_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .clk        (clk),
      .rst        (reset),
      .mode_i     (bus.mode),
      .wr_valid_i (bus.wr_valid),
      .rd_req_i   (bus.rd_req),
      .err_clr_i  (bus.err_clr),
      .addr_new_i (!valid_q[bus.write_pointer]),
      .flush_o    (flush),
      .wr_en_o    (wr_en),
      .rd_en_o    (rd_en),
      .wr_ready_o (bus.wr_ready),
      .wptr_o     (wptr),
      .rptr_o     (rptr),
      .count_o    (bus.count),
      .full_o     (bus.full),
      .empty_o    (bus.empty),
      .ovf_o      (bus.overflow_err),
      .unf_o      (bus.underflow_err)
   );

   always_comb begin
      fifo_mode = (bus.mode == IW_FIFO);
      widx      = fifo_mode ? wptr : bus.write_pointer;
      ridx      = fifo_mode ? rptr : bus.read_pointer;
      wr_word   = '{opc: bus.opcode, op_a: bus.operand_a, op_b: bus.operand_b};
   end

   // A FIFO read and write never share an index: equal pointers imply full or empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q      <= {DEPTH{RESET_WORD}};
         valid_q    <= '0;
         word_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_hit_q   <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         rd_hit_q   <= rd_en && valid_q[ridx];
         if (rd_en) word_q <= mem_q[ridx];
         if (wr_en) mem_q[widx] <= wr_word;
         if (flush) begin
            valid_q <= '0;
         end else begin
            if (rd_en && fifo_mode) valid_q[ridx] <= 1'b0;
            if (wr_en)              valid_q[widx] <= 1'b1;
         end
      end
   end

   assign bus.rd_valid         = rd_valid_q;
   assign bus.rd_hit           = rd_hit_q;
   assign bus.instruction_word = word_q;
endmodule

// File: tb/tb_instr_register_queue.sv
// Randomised and directed bench for instr_register_queue with a queue/array reference model.
// Expected reads are queued by the driver and retired by an independent output monitor.
module tb_instr_register_queue;
   import instr_register_pkg::*;

   localparam int unsigned DEPTH = 32;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instr_register_queue_if #(.DEPTH(DEPTH)) bus ();
   instr_register_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

   typedef struct {
      instruction_t w;
      logic         hit;
      int           due;
   } exp_t;

   exp_t         exp_q[$];
   instruction_t m_fifo[$];
   instruction_t m_mem[DEPTH];
   logic         m_val[DEPTH];
   int           m_wcnt;
   logic         m_armed, m_ovf, m_unf;
   iw_mode_t     m_mode, md;
   instruction_t m_last;
   int           cyc = 0;
   int           n_cmp = 0;
   int           n_err = 0;

   always @(posedge clk) cyc++;

   function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   function automatic int m_count();
      int c = 0;
      if (m_mode == IW_FIFO) return m_fifo.size();
      foreach (m_val[i]) c += int'(m_val[i]);
      return c;
   endfunction

   function automatic void model_reset();
      m_fifo.delete();
      exp_q.delete();
      foreach (m_mem[i]) begin
         m_mem[i] = '0;
         m_val[i] = 1'b0;
      end
      m_wcnt  = 0;
      m_armed = 1'b0;
      m_mode  = IW_ADDR;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_last  = '0;
   endfunction

   function automatic void check_status();
      int c = m_count();
      chk("count", bus.count, c);
      chk("full", bus.full, c == DEPTH);
      chk("empty", bus.empty, c == 0);
      chk("wr_ready", bus.wr_ready, (bus.mode == IW_ADDR) || (c != DEPTH));
      chk("overflow_err", bus.overflow_err, m_ovf);
      chk("underflow_err", bus.underflow_err, m_unf);
   endfunction

   // One clock of stimulus; the model is advanced with the rules applied to pre-edge state.
   task automatic step(iw_mode_t mode, logic wv, opcode_t op, int a, int b, int wp,
                       logic rr, int rp, logic clr);
      instruction_t w;
      logic full, empty;
      logic ovf_set = 1'b0;
      logic unf_set = 1'b0;
      w = '{opc: op, op_a: a, op_b: b};
      bus.mode = mode; bus.wr_valid = wv; bus.opcode = op;
      bus.operand_a = a; bus.operand_b = b; bus.write_pointer = AW'(wp);
      bus.rd_req = rr; bus.read_pointer = AW'(rp); bus.err_clr = clr;
      if (m_armed && mode != m_mode) begin
         m_fifo.delete();
         foreach (m_val[i]) m_val[i] = 1'b0;
         m_wcnt = 0;
      end else if (mode == IW_FIFO) begin
         full  = (m_fifo.size() == DEPTH);
         empty = (m_fifo.size() == 0);
         if (rr) begin
            if (empty) unf_set = 1'b1;
            else exp_q.push_back('{m_fifo.pop_front(), 1'b1, cyc + 1});
         end
         if (wv) begin
            if (full) ovf_set = 1'b1;
            else begin
               m_fifo.push_back(w);
               m_mem[m_wcnt % DEPTH] = w;
               m_wcnt++;
            end
         end
      end else begin
         if (rr) exp_q.push_back('{m_mem[rp], m_val[rp], cyc + 1});
         if (wv) begin
            m_mem[wp] = w;
            m_val[wp] = 1'b1;
         end
      end
      m_mode  = mode;
      m_armed = 1'b1;
      m_ovf   = ovf_set | (m_ovf & !clr);
      m_unf   = unf_set | (m_unf & !clr);
      @(posedge clk);
      @(negedge clk);
      check_status();
   endtask

   task automatic wr(iw_mode_t mode, int a);
      step(mode, 1'b1, PASSA, a, a + 1000, 0, 1'b0, 0, 1'b0);
   endtask

   task automatic rd(iw_mode_t mode, int rp);
      step(mode, 1'b0, ZERO, 0, 0, 0, 1'b1, rp, 1'b0);
   endtask

   task automatic clear(iw_mode_t mode);
      step(mode, 1'b0, ZERO, 0, 0, 0, 1'b0, 0, 1'b1);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      logic want;
      if (!reset) begin
         want = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         if (want || bus.rd_valid) chk("rd_valid", bus.rd_valid, want);
         if (want) begin
            e = exp_q.pop_front();
            if (bus.rd_valid) begin
               chk("instruction_word", bus.instruction_word, e.w);
               chk("rd_hit", bus.rd_hit, e.hit);
            end
            m_last = e.w;
         end else begin
            chk("word_hold", bus.instruction_word, m_last);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.mode = IW_ADDR; bus.wr_valid = 1'b0; bus.opcode = ZERO;
      bus.operand_a = 0; bus.operand_b = 0; bus.write_pointer = '0;
      bus.rd_req = 1'b0; bus.read_pointer = '0; bus.err_clr = 1'b0;
      model_reset();
      @(negedge clk);
      check_status();
      chk("reset_rd_valid", bus.rd_valid, 0);
      chk("reset_rd_hit", bus.rd_hit, 0);
      chk("reset_word", bus.instruction_word, 0);
      #1 reset = 1'b0;

      // ADDR random access, rewrite, same-index read/write
      step(IW_ADDR, 1'b1, ADD, 5, 3, 7, 1'b0, 0, 1'b0);
      rd(IW_ADDR, 7);
      rd(IW_ADDR, 8);
      step(IW_ADDR, 1'b1, ADD, 5, 3, 7, 1'b0, 0, 1'b0);
      chk("addr_rewrite_count", bus.count, 1);
      step(IW_ADDR, 1'b1, SUB, 9, 4, 7, 1'b1, 7, 1'b0);
      rd(IW_ADDR, 7);

      // switch to FIFO: that cycle's write is dropped, then fill and overflow
      step(IW_FIFO, 1'b1, MOD, 99, 99, 0, 1'b0, 0, 1'b0);
      chk("flush_count", bus.count, 0);
      for (int i = 0; i < 32; i++) wr(IW_FIFO, i);
      chk("fill_full", bus.full, 1);
      chk("fill_wr_ready", bus.wr_ready, 0);
      wr(IW_FIFO, 77);
      chk("fill_overflow", bus.overflow_err, 1);
      clear(IW_FIFO);
      step(IW_FIFO, 1'b1, DIV, 55, 0, 0, 1'b1, 0, 1'b0);
      chk("simul_full_count", bus.count, 31);
      for (int i = 0; i < 31; i++) rd(IW_FIFO, 0);
      chk("drain_empty", bus.empty, 1);

      // underflow, clear, simultaneous at empty, wrap
      rd(IW_FIFO, 0);
      chk("underflow_set", bus.underflow_err, 1);
      clear(IW_FIFO);
      step(IW_FIFO, 1'b1, PASSB, 123, 4, 0, 1'b1, 0, 1'b0);
      chk("simul_empty_count", bus.count, 1);
      rd(IW_FIFO, 0);
      for (int i = 0; i < 40; i++) begin
         wr(IW_FIFO, 200 + i);
         rd(IW_FIFO, 0);
      end
      for (int i = 0; i < 10; i++) wr(IW_FIFO, 300 + i);
      step(IW_FIFO, 1'b1, MULT, 400, 1, 0, 1'b1, 0, 1'b0);
      chk("simul_mid_count", bus.count, 10);
      for (int i = 0; i < 6; i++) rd(IW_FIFO, 0);

      // 4 valid entries, switch to ADDR with a write pending
      step(IW_ADDR, 1'b1, ADD, 1, 1, 3, 1'b0, 0, 1'b0);
      chk("switch_count", bus.count, 0);
      for (int i = 0; i < DEPTH; i++) rd(IW_ADDR, i);

      // randomised traffic with occasional mode changes and error clears
      md = IW_ADDR;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) md = (md == IW_FIFO) ? IW_ADDR : IW_FIFO;
         step(md, 1'($urandom_range(0, 1)), opcode_t'($urandom_range(0, 7)),
              int'($urandom), int'($urandom), int'($urandom_range(0, DEPTH - 1)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
              $urandom_range(0, 15) == 0);
      end

      // asynchronous reset mid-stream with read data on the outputs
      clear(IW_FIFO);
      clear(IW_FIFO);
      for (int i = 0; i < 5; i++) wr(IW_FIFO, 500 + i);
      rd(IW_FIFO, 0);
      #1 reset = 1'b1;
      #1;
      chk("async_count", bus.count, 0);
      chk("async_empty", bus.empty, 1);
      chk("async_word", bus.instruction_word, 0);
      chk("async_rd_valid", bus.rd_valid, 0);
      model_reset();
      @(negedge clk);
      #1 reset = 1'b0;
      wr(IW_FIFO, 600);
      chk("post_reset_first_write", bus.count, 1);
      rd(IW_FIFO, 0);
      clear(IW_FIFO);

      chk("pending_reads", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
